// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, one operand bit per clock, LSB first.
// start/busy/done handshake; sum/cout are registered and hold between ops.

// 1-bit full adder cell shared by every bit position of the serial add.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             load_s;
  logic             last_s;

  logic [WIDTH-1:0] areg_r;
  logic [WIDTH-1:0] breg_r;
  logic [WIDTH-1:0] pres_r;
  logic [WIDTH-1:0] pres_next_s;
  logic             c_r;
  logic [CW-1:0]    cnt_r;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             fa_sum_s;
  logic             fa_co_s;

  fa u_fa (
    .a  (areg_r[0]),
    .b  (breg_r[0]),
    .ci (c_r),
    .s  (fa_sum_s),
    .co (fa_co_s)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
  assign pres_next_s = (pres_r >> 1) | {fa_sum_s, {(WIDTH-1){1'b0}}};

  // Next-state decode plus operand-load and last-bit strobes.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s       = 1'b1;
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_BIT) begin
          last_s       = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          load_s       = 1'b1;
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register with registered busy/done flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == RUN);
      done_r  <= (next_state_s == DONE);
    end
  end

  // Operand capture and one-bit-per-cycle shift datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg_r <= {WIDTH{1'b0}};
      breg_r <= {WIDTH{1'b0}};
      pres_r <= {WIDTH{1'b0}};
      c_r    <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if (load_s) begin
      areg_r <= a;
      breg_r <= b;
      pres_r <= {WIDTH{1'b0}};
      c_r    <= cin;
      cnt_r  <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      areg_r <= areg_r >> 1;
      breg_r <= breg_r >> 1;
      pres_r <= pres_next_s;
      c_r    <= fa_co_s;
      // Wrap to zero on the last bit so the counter stays within WIDTH-1.
      cnt_r  <= last_s ? {CW{1'b0}} : (cnt_r + CW'(1));
    end
  end

  // Result registers: written only on the completing edge, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
    end else if (last_s) begin
      sum_r  <= pres_next_s;
      cout_r <= fa_co_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 directed ops plus a WIDTH=2
// exhaustive sweep. Expected {cout,sum} is queued at stimulus time and
// compared when done pulses.

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00;
  logic [7:0] b8 = 8'h00;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = 2'b00;
  logic [1:0] b2 = 2'b00;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  logic [8:0] q8[$];
  logic [2:0] q2[$];
  logic       prev_done8 = 1'b0;
  logic       prev_done2 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // WIDTH=8 monitor: each done pulse is one cycle wide and matches the queue head.
  always @(negedge clk) begin
    if (done8) begin
      check("done8_width", 64'(prev_done8), 64'd0);
      if (q8.size() == 0) begin
        check("done8_unexpected", 64'd1, 64'd0);
      end else begin
        check("sum8", 64'({cout8, sum8}), 64'(q8.pop_front()));
      end
    end
    prev_done8 <= done8;
  end

  // WIDTH=2 monitor.
  always @(negedge clk) begin
    if (done2) begin
      check("done2_width", 64'(prev_done2), 64'd0);
      if (q2.size() == 0) begin
        check("done2_unexpected", 64'd1, 64'd0);
      end else begin
        check("sum2", 64'({cout2, sum2}), 64'(q2.pop_front()));
      end
    end
    prev_done2 <= done2;
  end

  // Called at a negedge; counts negedges until done, checking busy meanwhile.
  task automatic wait_done8(input int exp_lat, input string tag);
    int cyc;
    cyc = 0;
    while (!done8 && cyc < 40) begin
      check("busy8_run", 64'(busy8), 64'd1);
      @(negedge clk);
      cyc++;
    end
    check(tag, 64'(cyc), 64'(exp_lat));
    check("busy8_in_done", 64'(busy8), 64'd0);
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    q8.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cv});
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(8, "lat8");
  endtask

  task automatic op2(input logic [1:0] av, input logic [1:0] bv, input logic cv);
    int cyc;
    @(negedge clk);
    a2 = av; b2 = bv; cin2 = cv; start2 = 1'b1;
    q2.push_back({1'b0, av} + {1'b0, bv} + {2'd0, cv});
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("lat2", 64'(cyc), 64'd2);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_sum", 64'({cout8, sum8}), 64'd0);
    check("rst_sum2", 64'({cout2, sum2}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed WIDTH=8 ops.
    op8(8'h3C, 8'h42, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hA5, 8'h5A, 1'b1);

    // Exhaustive WIDTH=2 sweep.
    for (int ai = 0; ai < 4; ai++)
      for (int bi = 0; bi < 4; bi++)
        for (int ci = 0; ci < 2; ci++)
          op2(2'(ai), 2'(bi), 1'(ci));

    // Start held high: mid-op operand change ignored, second op captured in DONE.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h030);
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01;
    q8.push_back(9'h002);
    wait_done8(8, "b2b_lat1");
    @(negedge clk);
    start8 = 1'b0;
    check("b2b_recapture", 64'(busy8), 64'd1);
    wait_done8(8, "b2b_lat2");

    // start pulsed during RUN with other operands is ignored.
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h01E);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    repeat (2) @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; cin8 = 1'b0;
    wait_done8(5, "run_start_lat");
    repeat (12) @(negedge clk);

    // Asynchronous reset in the middle of an op.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 64'(busy8), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", 64'(busy8), 64'd0);
    check("async_done", 64'(done8), 64'd0);
    check("async_sum", 64'(sum8), 64'd0);
    check("async_cout", 64'(cout8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 64'(busy8), 64'd0);
    check("post_rst_sum", 64'({cout8, sum8}), 64'd0);
    op8(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);

    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
